// File: rtl/csel_multiword_seq.sv
// Multi-cycle WORDS*8-bit add/subtract sequencer driving one external 8-bit
// carry-select adder slice, least-significant byte first, one byte per clock.
module csel_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    input  logic                 ci,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   sum,
    output logic                 co,
    output logic [7:0]           slc_a,
    output logic [7:0]           slc_b,
    output logic                 slc_ci,
    output logic                 slc_c0,
    output logic                 slc_c1,
    input  logic [7:0]           slc_s,
    input  logic                 slc_co
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [WORDS-1:0][7:0]  op_a;
    logic [WORDS-1:0][7:0]  op_b;
    logic [WORDS-1:0][7:0]  sum_r;
    logic                   carry;
    logic                   accept;

    // A request is taken only between operations, including the DONE cycle.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            co    <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            op_a  <= a;
            op_b  <= b ^ {(8*WORDS){sub}};
            carry <= sub | ci;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[idx] <= slc_s;
            carry      <= slc_co;
            if (idx == LAST) begin
                co    <= slc_co;
                state <= DONE;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign sum    = sum_r;

    // Slice inputs are parked at zero whenever no byte is being processed.
    assign slc_a  = busy ? op_a[idx] : 8'h00;
    assign slc_b  = busy ? op_b[idx] : 8'h00;
    assign slc_ci = busy & carry;
    assign slc_c0 = 1'b0;
    assign slc_c1 = 1'b1;

endmodule

// File: tb/tb_csel_multiword_seq.sv
// Directed self-checking bench for csel_multiword_seq (WORDS=4) with a
// behavioural 8-bit adder standing in for the external carry-select slice.
module tb_csel_multiword_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        co;
    logic [7:0]  slc_a;
    logic [7:0]  slc_b;
    logic        slc_ci;
    logic        slc_c0;
    logic        slc_c1;
    logic [7:0]  slc_s;
    logic        slc_co;

    int checks = 0;
    int errors = 0;

    csel_multiword_seq #(.WORDS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .co     (co),
        .slc_a  (slc_a),
        .slc_b  (slc_b),
        .slc_ci (slc_ci),
        .slc_c0 (slc_c0),
        .slc_c1 (slc_c1),
        .slc_s  (slc_s),
        .slc_co (slc_co)
    );

    assign {slc_co, slc_s} = {1'b0, slc_a} + {1'b0, slc_b} + {8'b0, slc_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a request at a falling edge, lets the next rising edge (E0)
    // accept it, then drops start and returns in RUN cycle 0.
    task automatic applyStimulus(input logic s, input logic [31:0] av, input logic [31:0] bv, input logic c);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        ci    = c;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic runOp(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic [31:0] exp_sum, input logic exp_co,
                         output logic [3:0] ci_seq);
        applyStimulus(s, av, bv, c);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) stepCycle();
            ci_seq[k] = slc_ci;
            checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
            checkOutput({tag, "_nodone"}, {31'b0, done}, 32'd0);
        end
        stepCycle();
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
        checkOutput({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_sum"}, sum, exp_sum);
        checkOutput({tag, "_co"}, {31'b0, co}, {31'b0, exp_co});
        stepCycle();
        checkOutput({tag, "_done_once"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_sum_hold"}, sum, exp_sum);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] seq;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_sum", sum, 32'd0);
        checkOutput("rst_co", {31'b0, co}, 32'd0);
        checkOutput("rst_c0c1", {30'b0, slc_c0, slc_c1}, 32'd1);
        rst_n = 1'b1;
        stepCycle();

        runOp("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, seq);
        checkOutput("idle_slc_a", {24'b0, slc_a}, 32'd0);
        checkOutput("idle_slc_b", {24'b0, slc_b}, 32'd0);

        runOp("sub_borrow", 1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, seq);
        runOp("sub_pos", 1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, seq);
        runOp("add_ci", 1'b0, 32'h12345678, 32'h0000FF88, 1'b1, 32'h12355601, 1'b0, seq);
        checkOutput("add_ci_slc_ci_seq", {28'b0, seq}, 32'h00000007);

        // Second request arrives mid-RUN and must leave the operation untouched.
        applyStimulus(1'b0, 32'h11111111, 32'h22222222, 1'b0);
        stepCycle();
        start = 1'b1;
        sub   = 1'b1;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        stepCycle();
        start = 1'b0;
        checkOutput("ign_busy", {31'b0, busy}, 32'd1);
        checkOutput("ign_slc_a", {24'b0, slc_a}, 32'h11);
        checkOutput("ign_slc_b", {24'b0, slc_b}, 32'h22);
        stepCycle();
        stepCycle();
        checkOutput("ign_done", {31'b0, done}, 32'd1);
        checkOutput("ign_sum", sum, 32'h33333333);
        checkOutput("ign_co", {31'b0, co}, 32'd0);
        stepCycle();

        // Back-to-back: start held across the DONE cycle relaunches at once.
        applyStimulus(1'b0, 32'h01020304, 32'h10203040, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'hFFFFFFFF;
        b     = 32'h00000000;
        ci    = 1'b1;
        stepCycle();
        checkOutput("b2b_done1", {31'b0, done}, 32'd1);
        checkOutput("b2b_sum1", sum, 32'h11223344);
        stepCycle();
        start = 1'b0;
        checkOutput("b2b_restart_busy", {31'b0, busy}, 32'd1);
        checkOutput("b2b_restart_nodone", {31'b0, done}, 32'd0);
        checkOutput("b2b_sum_stable", sum, 32'h11223344);
        checkOutput("b2b_slc_a", {24'b0, slc_a}, 32'hFF);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("b2b_still_busy", {31'b0, busy}, 32'd1);
        stepCycle();
        checkOutput("b2b_done2", {31'b0, done}, 32'd1);
        checkOutput("b2b_sum2", sum, 32'h00000000);
        checkOutput("b2b_co2", {31'b0, co}, 32'd1);
        stepCycle();

        // Reset pulled mid-RUN after two bytes have already been written.
        applyStimulus(1'b0, 32'h55555555, 32'h11111111, 1'b0);
        stepCycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_sum", sum, 32'd0);
        checkOutput("mid_rst_co", {31'b0, co}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen_done;
            seen_done = 1'b0;
            repeat (6) begin
                stepCycle();
                seen_done = seen_done | done;
            end
            checkOutput("mid_rst_no_done", {31'b0, seen_done}, 32'd0);
        end
        runOp("post_rst", 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, seq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
